// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage:
// FSM state encoding, the NOP word and the PC step.
package rv_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_INC   = 32'd4;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/if_lat_cnt.sv
// Loadable 2-bit down-counter with zero flag; paces the WAIT state of
// the fetch FSM. Saturates at zero so an extra decrement is harmless.
module if_lat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [1:0] cnt_q;

    // Load takes priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      cnt_q <= 2'd0;
        else if (load_i)                 cnt_q <= load_val_i;
        else if (dec_i && cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
    end

    assign zero_o = (cnt_q == 2'd0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage of the multicycle RV32I core. Owns the PC,
// issues reads to a synchronous instruction memory, holds the fetched
// word under a valid/ready handshake, accepts redirects from execute
// and freezes permanently on halt.
// Optional feature macro: IF_MISALIGN_TRAP_EN -- a misaligned redirect
// is refused, sets a sticky misalign_err and halts fetch. Without it the
// target's low two bits are cleared and misalign_err is tied low.
module inst_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_AW      = 12,
    parameter int          IMEM_LATENCY = 1
) (
    input  logic               CLK,
    input  logic               RSTn,
    output logic               I_MEM_CSN,
    output logic [IMEM_AW-1:0] I_MEM_ADDR,
    input  logic [31:0]        I_MEM_DI,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        inst,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               redir_valid,
    input  logic [31:0]        redir_pc,
    input  logic               halt,
    output logic               halted,
    output logic               misalign_err
);

    localparam logic [1:0] LAT_LOAD = 2'(IMEM_LATENCY - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;       // fetch PC
    logic [31:0]  inst_q, inst_d;   // captured instruction
    logic [31:0]  ipc_q, ipc_d;     // address of captured instruction
    logic         lat_zero;

    if_lat_cnt u_lat_cnt (
        .clk        (CLK),
        .rst_n      (RSTn),
        .load_i     (state_q == ST_REQ),
        .load_val_i (LAT_LOAD),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (lat_zero)
    );

`ifdef IF_MISALIGN_TRAP_EN
    logic err_q, err_d;

    // Sticky misaligned-redirect flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

    // State, PC and captured-instruction registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
        end
    end

    // Next-state logic: normal sequencing first, then redirect and halt
    // override it (halt has the last word, so it wins over both).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
`ifdef IF_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (lat_zero) begin
                    inst_d  = I_MEM_DI;
                    ipc_d   = pc_q;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (id_ready) begin
                    pc_d    = pc_q + PC_INC;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_HALTED;
        endcase

        if (state_q != ST_HALTED) begin
            if (redir_valid) begin
                // An in-flight read is dropped: keep the old inst/pc.
                inst_d = inst_q;
                ipc_d  = ipc_q;
`ifdef IF_MISALIGN_TRAP_EN
                if (redir_pc[1:0] != 2'b00) begin
                    err_d   = 1'b1;
                    pc_d    = pc_q;
                    state_d = ST_HALTED;
                end else begin
                    pc_d    = redir_pc;
                    state_d = ST_REQ;
                end
`else
                pc_d    = word_align(redir_pc);
                state_d = ST_REQ;
`endif
            end
            if (halt) begin
                pc_d    = pc_q;
                inst_d  = inst_q;
                ipc_d   = ipc_q;
`ifdef IF_MISALIGN_TRAP_EN
                err_d   = err_q;
`endif
                state_d = ST_HALTED;
            end
        end
    end

    assign I_MEM_CSN  = (state_q != ST_REQ);
    assign I_MEM_ADDR = pc_q[IMEM_AW-1:0];
    assign id_valid   = (state_q == ST_HOLD);
    assign halted     = (state_q == ST_HALTED);
    assign inst       = inst_q;
    assign pc         = ipc_q;
    assign pc_plus4   = ipc_q + PC_INC;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: two instances (latency 1 at PC 0, latency 3 at a
// PC near 2^32 so wrap-around is exercised) share random stimulus and
// are each checked every cycle against a transaction-level model.
module tb_inst_fetch;

    logic        CLK  = 1'b0;
    logic        RSTn = 1'b0;
    logic        halt;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        id_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    // Memory content: each word is tagged with its own byte address.
    function automatic logic [31:0] tagw(input logic [11:0] a);
        return {16'hC0DE, 4'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_if
        localparam int          L   = (gi == 0) ? 1 : 3;
        localparam logic [31:0] RPC = (gi == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;

        logic        csn, vld, hlt, err;
        logic [11:0] addr;
        logic [31:0] di, inst, pc, pc4;
        logic [31:0] mem_pipe [L];

        inst_fetch #(.RESET_PC(RPC), .IMEM_AW(12), .IMEM_LATENCY(L)) dut (
            .CLK          (CLK),
            .RSTn         (RSTn),
            .I_MEM_CSN    (csn),
            .I_MEM_ADDR   (addr),
            .I_MEM_DI     (di),
            .id_valid     (vld),
            .id_ready     (id_ready),
            .inst         (inst),
            .pc           (pc),
            .pc_plus4     (pc4),
            .redir_valid  (redir_valid),
            .redir_pc     (redir_pc),
            .halt         (halt),
            .halted       (hlt),
            .misalign_err (err)
        );

        // Synchronous memory with L-cycle latency; garbage when not selected.
        always @(posedge CLK) begin
            mem_pipe[0] <= csn ? (32'hBAD0_0000 | 32'($urandom_range(0, 255))) : tagw(addr);
            for (int k = 1; k < L; k++) mem_pipe[k] <= mem_pipe[k-1];
        end
        assign di = mem_pipe[L-1];

        // Model: a fetch is a request cycle followed by L wait cycles, then
        // the word f(pc) is presented until accepted.
        bit          m_idle, m_hold, m_halt, m_err;
        int          m_step;
        logic [31:0] m_pc, m_inst, m_ipc;

        initial forever begin
            @(posedge CLK);
            if (!RSTn) begin
                m_idle = 1; m_hold = 0; m_halt = 0; m_err = 0; m_step = 0;
                m_pc = RPC; m_inst = 32'h0000_0013; m_ipc = RPC;
            end else if (m_halt) begin
                // frozen until reset
            end else if (halt) begin
                m_halt = 1;
            end else if (redir_valid) begin
`ifdef IF_MISALIGN_TRAP_EN
                if (redir_pc[1:0] != 2'b00) begin
                    m_err = 1; m_halt = 1;
                end else begin
                    m_pc = redir_pc; m_idle = 0; m_hold = 0; m_step = 0;
                end
`else
                m_pc = {redir_pc[31:2], 2'b00}; m_idle = 0; m_hold = 0; m_step = 0;
`endif
            end else if (m_idle) begin
                m_idle = 0; m_step = 0;
            end else if (m_hold) begin
                if (id_ready) begin
                    m_pc = m_pc + 32'd4; m_hold = 0; m_step = 0;
                end
            end else if (m_step == L) begin
                m_inst = tagw(m_pc[11:0]); m_ipc = m_pc; m_hold = 1;
            end else begin
                m_step++;
            end
        end

        // Per-cycle comparison away from the active edge.
        initial forever begin
            @(negedge CLK);
            if (RSTn) begin
                chk($sformatf("L%0d csn", L),  {31'b0, csn},
                    {31'b0, !(!m_halt && !m_idle && !m_hold && m_step == 0)});
                chk($sformatf("L%0d addr", L), {20'b0, addr}, {20'b0, m_pc[11:0]});
                chk($sformatf("L%0d valid", L), {31'b0, vld}, {31'b0, m_hold && !m_halt});
                chk($sformatf("L%0d halted", L), {31'b0, hlt}, {31'b0, m_halt});
                chk($sformatf("L%0d merr", L), {31'b0, err}, {31'b0, m_err});
                chk($sformatf("L%0d inst", L), inst, m_inst);
                chk($sformatf("L%0d pc", L),   pc,   m_ipc);
                chk($sformatf("L%0d pc4", L),  pc4,  m_ipc + 32'd4);
            end
        end

        // Asynchronous reset must take effect without waiting for a clock.
        initial forever begin
            @(negedge RSTn);
            #1;
            chk($sformatf("L%0d rst csn", L),  {31'b0, csn}, 32'd1);
            chk($sformatf("L%0d rst valid", L), {31'b0, vld}, 32'd0);
            chk($sformatf("L%0d rst halted", L), {31'b0, hlt}, 32'd0);
            chk($sformatf("L%0d rst merr", L), {31'b0, err}, 32'd0);
            chk($sformatf("L%0d rst inst", L), inst, 32'h0000_0013);
            chk($sformatf("L%0d rst pc", L),   pc, RPC);
            chk($sformatf("L%0d rst addr", L), {20'b0, addr}, {20'b0, RPC[11:0]});
        end
    end

    initial begin
        halt = 0; redir_valid = 0; redir_pc = 0; id_ready = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1 RSTn = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK); #1;
            if (c % 250 == 249) begin
                // mid-cycle reset pulse spanning one rising edge
                halt = 0; redir_valid = 0;
                #2 RSTn = 1'b0;
                @(posedge CLK);
                @(negedge CLK); #1 RSTn = 1'b1;
            end else if (c < 20) begin
                // clean start-up: steady flow, no disturbances
                id_ready = 1; halt = 0; redir_valid = 0;
            end else begin
                id_ready    = ($urandom_range(0, 3) != 0);
                halt        = ($urandom_range(0, 299) == 0);
                redir_valid = ($urandom_range(0, 9) == 0);
                redir_pc    = $urandom;
                if ($urandom_range(0, 7) != 0) redir_pc[1:0] = 2'b00;
                if ($urandom_range(0, 1) != 0) redir_pc[31:12] = 20'h0;
            end
        end
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
